// File: rtl/spi_word_sequencer.sv
// Word-level queue in front of an SPI master: buffers TX words, issues one start per word,
// and collects each received word into an RX FIFO.
module spi_word_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned RX_DEPTH   = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             m_start,
    output logic [WIDTH-1:0] m_tx_data,
    input  logic             m_done,
    input  logic [WIDTH-1:0] m_rx_data,
    output logic             busy,
    output logic             err_timeout
);
    localparam int unsigned TxAw   = $clog2(TX_DEPTH);
    localparam int unsigned RxAw   = $clog2(RX_DEPTH);
    localparam int unsigned TxCw   = TxAw + 1;
    localparam int unsigned RxCw   = RxAw + 1;
    localparam int unsigned CntMax = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [TxCw-1:0] TxFull  = TxCw'(TX_DEPTH);
    localparam logic [RxCw-1:0] RxFull  = RxCw'(RX_DEPTH);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StGap} state_e;

    localparam state_e AfterXfer = (GAP_CYCLES == 0) ? StIdle : StGap;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TxAw-1:0]  tx_wr_q, tx_rd_q;
    logic [TxCw-1:0]  tx_cnt_q, tx_cnt_d;
    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RxAw-1:0]  rx_wr_q, rx_rd_q;
    logic [RxCw-1:0]  rx_cnt_q, rx_cnt_d;

    logic tx_push, tx_pop, rx_push, rx_pop;

    assign in_ready  = (tx_cnt_q != TxFull);
    assign out_valid = (rx_cnt_q != '0);
    assign tx_push   = in_valid && in_ready;
    assign rx_pop    = out_valid && out_ready;
    assign out_data  = out_valid ? rx_mem[rx_rd_q] : '0;
    assign m_tx_data = (state_q == StStart || state_q == StWait) ? tx_mem[tx_rd_q] : '0;
    assign busy      = (state_q != StIdle) || (tx_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_start     = 1'b0;
        err_timeout = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A free RX slot is reserved up front so a completed word is never dropped.
                if (tx_cnt_q != '0 && rx_cnt_q != RxFull) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                m_start = 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (m_done) begin
                    rx_push = 1'b1;
                    tx_pop  = 1'b1;
                    cnt_d   = '0;
                    state_d = AfterXfer;
                end else if (cnt_q == TmoLast) begin
                    tx_pop      = 1'b1;
                    err_timeout = 1'b1;
                    cnt_d       = '0;
                    state_d     = AfterXfer;
                end
            end
            StGap: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + TxCw'(1);
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - TxCw'(1);
        end
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + RxCw'(1);
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - RxCw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxAw'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters alone.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= in_data;
        if (rx_push) rx_mem[rx_wr_q] <= m_rx_data;
    end

endmodule

// File: tb/tb_spi_word_sequencer.sv
// Bench for spi_word_sequencer: two instances (GAP_CYCLES 2 and 0) checked every cycle against
// a queue/timestamp model, plus directed scenarios with hand-computed expectations.
module tb_spi_word_sequencer;
    localparam int unsigned W     = 8;
    localparam int unsigned Depth = 4;
    localparam int          Tmo   = 64;
    localparam int          GapA  = 2;
    localparam int          GapB  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic                out_ready;
    logic [1:0]          in_valid, in_ready, out_valid, m_start, m_done, busy, err_timeout;
    logic [1:0][W-1:0]   in_data, out_data, m_tx_data, m_rx_data;

    spi_word_sequencer #(
        .WIDTH(W), .TX_DEPTH(Depth), .RX_DEPTH(Depth), .GAP_CYCLES(GapA), .TIMEOUT(Tmo)
    ) u_gap2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .m_start(m_start[0]), .m_tx_data(m_tx_data[0]),
        .m_done(m_done[0]), .m_rx_data(m_rx_data[0]), .busy(busy[0]),
        .err_timeout(err_timeout[0])
    );

    spi_word_sequencer #(
        .WIDTH(W), .TX_DEPTH(Depth), .RX_DEPTH(Depth), .GAP_CYCLES(GapB), .TIMEOUT(Tmo)
    ) u_gap0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .m_start(m_start[1]), .m_tx_data(m_tx_data[1]),
        .m_done(m_done[1]), .m_rx_data(m_rx_data[1]), .busy(busy[1]),
        .err_timeout(err_timeout[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic armed;

    // Sources, master knobs, model and logs.
    logic [W-1:0] src [2][$];
    logic [1:0]   acc;
    int           mdelay;
    logic         mstall, inj_done;
    logic [1:0]   mact;
    int           mk [2];
    logic [W-1:0] mtx [2][$];
    logic [W-1:0] mrx [2][$];
    logic [1:0]   xfer;
    int           t0 [2];
    int           free_at [2];
    int           st_cyc [2][$];
    logic [W-1:0] st_dat [2][$];
    int           err_cyc [2][$];
    logic [W-1:0] rx_log [2][$];

    logic [W-1:0] exp1 [3] = '{8'h5A, 8'hC3, 8'h00};
    logic [W-1:0] exp2 [6] = '{8'hEF, 8'hEE, 8'hED, 8'hEC, 8'hEB, 8'hEA};
    logic [W-1:0] exp3 [8] = '{8'hDF, 8'hDE, 8'hDD, 8'hDC, 8'hDB, 8'hDA, 8'hD9, 8'hD8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the edge.
    task automatic model_cycle(input int i);
        bit wait_ph, done_now, tmo_now, go, room, rx_has;
        logic [W-1:0] e_tx, e_out;
        int g;
        g = (i == 0) ? GapA : GapB;
        acc[i] = in_valid[i] & in_ready[i];
        if (!armed) return;
        wait_ph  = xfer[i] && (cyc > t0[i]);
        done_now = wait_ph && (m_done[i] === 1'b1);
        tmo_now  = wait_ph && (m_done[i] !== 1'b1) && (cyc - t0[i] == Tmo);
        room     = mtx[i].size() < Depth;
        rx_has   = mrx[i].size() != 0;
        e_tx     = (xfer[i] && cyc >= t0[i] && mtx[i].size() != 0) ? mtx[i][0] : '0;
        e_out    = rx_has ? mrx[i][0] : '0;
        chk($sformatf("in_ready[%0d]", i), in_ready[i], room);
        chk($sformatf("out_valid[%0d]", i), out_valid[i], rx_has);
        chk($sformatf("out_data[%0d]", i), out_data[i], e_out);
        chk($sformatf("m_start[%0d]", i), m_start[i], xfer[i] && cyc == t0[i]);
        chk($sformatf("m_tx_data[%0d]", i), m_tx_data[i], e_tx);
        chk($sformatf("err_timeout[%0d]", i), err_timeout[i], tmo_now);
        chk($sformatf("busy[%0d]", i), busy[i],
            xfer[i] || mtx[i].size() != 0 || cyc < free_at[i]);
        if (m_start[i] === 1'b1) begin
            st_cyc[i].push_back(cyc);
            st_dat[i].push_back(m_tx_data[i]);
        end
        if (err_timeout[i] === 1'b1) err_cyc[i].push_back(cyc);
        if (out_valid[i] === 1'b1 && out_ready) rx_log[i].push_back(out_data[i]);
        if (reset) begin
            mtx[i].delete();
            mrx[i].delete();
            xfer[i]    = 1'b0;
            free_at[i] = 0;
        end else begin
            go = !xfer[i] && cyc >= free_at[i] && mtx[i].size() != 0 && mrx[i].size() < Depth;
            if (rx_has && out_ready) void'(mrx[i].pop_front());
            if (done_now) mrx[i].push_back(m_rx_data[i]);
            if (done_now || tmo_now) begin
                void'(mtx[i].pop_front());
                xfer[i]    = 1'b0;
                free_at[i] = cyc + 1 + g;
            end
            if (in_valid[i] && room) mtx[i].push_back(in_data[i]);
            if (go) begin
                xfer[i] = 1'b1;
                t0[i]   = cyc + 1;
            end
        end
    endtask

    // Word source and SPI master responder for one instance.
    task automatic drive_side(input int i);
        if (acc[i] === 1'b1 && src[i].size() != 0) void'(src[i].pop_front());
        in_valid[i] = src[i].size() != 0;
        in_data[i]  = (src[i].size() != 0) ? src[i][0] : '0;
        m_done[i]   = 1'b0;
        if (m_start[i] === 1'b1) begin
            mact[i] = 1'b1;
            mk[i]   = 0;
        end else if (mact[i]) begin
            mk[i]++;
        end
        if (mact[i] && !mstall && mk[i] >= mdelay) begin
            m_done[i]    = 1'b1;
            m_rx_data[i] = ~m_tx_data[i];
            mact[i]      = 1'b0;
        end
        if (inj_done) begin
            m_done[i]    = 1'b1;
            m_rx_data[i] = 8'h77;
        end
    endtask

    initial begin : engine
        armed = 1'b0; xfer = '0; mact = '0; acc = '0;
        m_done = '0; m_rx_data = '0; in_valid = '0; in_data = '0;
        for (int i = 0; i < 2; i++) begin
            t0[i] = 0; free_at[i] = 0; mk[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) model_cycle(i);
            if (reset) armed = 1'b1;
            @(posedge clk);
            #2;
            for (int i = 0; i < 2; i++) drive_side(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            st_cyc[i].delete(); st_dat[i].delete(); err_cyc[i].delete(); rx_log[i].delete();
        end
    endtask

    task automatic push_words(input logic [W-1:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            src[0].push_back(first + W'(k));
            src[1].push_back(first + W'(k));
        end
    endtask

    task automatic settle(input string name);
        int k;
        for (k = 0; k < 400 && !(busy == 2'b00 && out_valid == 2'b00 && src[0].size() == 0
                                 && src[1].size() == 0); k++) tick();
        chk(name, k < 400, 1'b1);
    endtask

    initial begin : stim
        int k, p;
        reset = 1'b1; out_ready = 1'b1; mdelay = 12; mstall = 1'b0; inj_done = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 2'b11);
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_busy", busy, 2'b00);

        // 1: three words, master answers ~tx after 12 cycles.
        clear_logs();
        p = cyc;
        src[0].push_back(8'hA5); src[0].push_back(8'h3C); src[0].push_back(8'hFF);
        src[1].push_back(8'hA5); src[1].push_back(8'h3C); src[1].push_back(8'hFF);
        for (k = 0; k < 300 && !(rx_log[0].size() == 3 && rx_log[1].size() == 3
                                 && busy == 2'b00); k++) tick();
        chk("t1_complete", k < 300, 1'b1);
        chk("t1_first_start", st_cyc[0].size() > 0 ? st_cyc[0][0] : -1, p + 2);
        chk("t1_tx0", st_dat[0].size() > 0 ? st_dat[0][0] : 8'h11, 8'hA5);
        chk("t1_tx1", st_dat[0].size() > 1 ? st_dat[0][1] : 8'h11, 8'h3C);
        chk("t1_tx2", st_dat[0].size() > 2 ? st_dat[0][2] : 8'h11, 8'hFF);
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("t1_rx_a%0d", j), rx_log[0].size() > j ? rx_log[0][j] : 8'h11, exp1[j]);
            chk($sformatf("t1_rx_b%0d", j), rx_log[1].size() > j ? rx_log[1][j] : 8'h11, exp1[j]);
        end
        chk("t1_spacing_gap2", st_cyc[0].size() > 1 ? st_cyc[0][1] - st_cyc[0][0] : -1, 16);
        chk("t1_spacing_gap0", st_cyc[1].size() > 1 ? st_cyc[1][1] - st_cyc[1][0] : -1, 14);
        settle("t1_settle");

        // 2: RX backpressure stalls after four transfers with two words still queued.
        clear_logs();
        out_ready = 1'b0; mdelay = 6;
        push_words(8'h10, 6);
        for (k = 0; k < 300 && !(st_cyc[0].size() == 4 && st_cyc[1].size() == 4); k++) tick();
        chk("t2_four_starts", k < 300, 1'b1);
        repeat (30) tick();
        chk("t2_starts_a", st_cyc[0].size(), 4);
        chk("t2_starts_b", st_cyc[1].size(), 4);
        chk("t2_in_ready", in_ready, 2'b11);
        chk("t2_out_valid", out_valid, 2'b11);
        chk("t2_busy", busy, 2'b11);
        out_ready = 1'b1;
        for (k = 0; k < 300 && !(rx_log[0].size() == 6 && rx_log[1].size() == 6); k++) tick();
        chk("t2_drain", k < 300, 1'b1);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("t2_rx_a%0d", j), rx_log[0].size() > j ? rx_log[0][j] : 8'h11, exp2[j]);
            chk($sformatf("t2_rx_b%0d", j), rx_log[1].size() > j ? rx_log[1][j] : 8'h11, exp2[j]);
        end
        settle("t2_settle");

        // 3: master stalled, source holds valid for eight words.
        clear_logs();
        mstall = 1'b1; mdelay = 4;
        push_words(8'h20, 8);
        repeat (10) tick();
        chk("t3_in_ready_low", in_ready, 2'b00);
        chk("t3_src_left", src[0].size(), 4);
        mstall = 1'b0;
        for (k = 0; k < 400 && !(rx_log[0].size() == 8 && rx_log[1].size() == 8); k++) tick();
        chk("t3_drain", k < 400, 1'b1);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_rx_a%0d", j), rx_log[0].size() > j ? rx_log[0][j] : 8'h11, exp3[j]);
            chk($sformatf("t3_rx_b%0d", j), rx_log[1].size() > j ? rx_log[1][j] : 8'h11, exp3[j]);
        end
        chk("t3_no_err", err_cyc[0].size() + err_cyc[1].size(), 0);
        settle("t3_settle");

        // 4: first word times out, second gets done exactly in its timeout cycle.
        clear_logs();
        mstall = 1'b1;
        push_words(8'h40, 2);
        for (k = 0; k < 200 && err_cyc[0].size() == 0; k++) tick();
        chk("t4_err_seen", k < 200, 1'b1);
        mstall = 1'b0; mdelay = Tmo;
        chk("t4_err_delay", err_cyc[0].size() > 0 && st_cyc[0].size() > 0 ?
            err_cyc[0][0] - st_cyc[0][0] : -1, 64);
        for (k = 0; k < 300 && !(rx_log[0].size() == 1 && rx_log[1].size() == 1); k++) tick();
        chk("t4_capture", k < 300, 1'b1);
        chk("t4_rx_a", rx_log[0].size() > 0 ? rx_log[0][0] : 8'h11, 8'hBE);
        chk("t4_rx_b", rx_log[1].size() > 0 ? rx_log[1][0] : 8'h11, 8'hBE);
        chk("t4_single_err", err_cyc[0].size(), 1);
        chk("t4_restart_gap2", st_cyc[0].size() > 1 ? st_cyc[0][1] - st_cyc[0][0] : -1, 68);
        chk("t4_restart_gap0", st_cyc[1].size() > 1 ? st_cyc[1][1] - st_cyc[1][0] : -1, 66);
        settle("t4_settle");

        // 5: reset in the middle of a transfer; the master's later done must be ignored.
        clear_logs();
        mdelay = 20;
        push_words(8'h55, 2);
        for (k = 0; k < 20 && st_cyc[0].size() == 0; k++) tick();
        chk("t5_started", k < 20, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        src[0].delete(); src[1].delete();
        tick();
        reset = 1'b0;
        chk("t5_m_start", m_start, 2'b00);
        chk("t5_busy", busy, 2'b00);
        chk("t5_out_valid", out_valid, 2'b00);
        chk("t5_in_ready", in_ready, 2'b11);
        repeat (40) tick();
        chk("t5_late_done_rx", rx_log[0].size() + rx_log[1].size(), 0);
        chk("t5_no_restart", st_cyc[0].size(), 1);
        chk("t5_idle_busy", busy, 2'b00);

        // 6: zero-gap instance restarts every 6 cycles; stray done during START is ignored.
        clear_logs();
        mdelay = 4;
        p = cyc;
        push_words(8'h01, 3);
        tick();
        tick();
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        for (k = 0; k < 200 && !(rx_log[0].size() == 3 && rx_log[1].size() == 3); k++) tick();
        chk("t6_complete", k < 200, 1'b1);
        chk("t6_start0", st_cyc[1].size() > 0 ? st_cyc[1][0] : -1, p + 2);
        chk("t6_start1", st_cyc[1].size() > 1 ? st_cyc[1][1] : -1, p + 8);
        chk("t6_start2", st_cyc[1].size() > 2 ? st_cyc[1][2] : -1, p + 14);
        chk("t6_gap2_spacing", st_cyc[0].size() > 1 ? st_cyc[0][1] - st_cyc[0][0] : -1, 8);
        chk("t6_rx0", rx_log[1].size() > 0 ? rx_log[1][0] : 8'h11, 8'hFE);
        chk("t6_rx1", rx_log[1].size() > 1 ? rx_log[1][1] : 8'h11, 8'hFD);
        chk("t6_rx2", rx_log[1].size() > 2 ? rx_log[1][2] : 8'h11, 8'hFC);
        settle("t6_settle");
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (5) tick();
        chk("t6_idle_done_ignored", out_valid, 2'b00);
        chk("t6_rx_count", rx_log[1].size(), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
